// File: rtl/song_reader.sv
// song_reader: walks a song ROM and hands {note, duration} words
// to the note player, one load strobe per note.
module song_reader #(
  parameter int SONG_BITS = 2,
  parameter int IDX_BITS  = 5
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          play,
  input  logic [SONG_BITS-1:0]          song,
  input  logic                          note_done,
  output logic [SONG_BITS+IDX_BITS-1:0] rom_addr,
  input  logic [11:0]                   rom_data,
  output logic [5:0]                    note,
  output logic [5:0]                    duration,
  output logic                          new_note,
  output logic                          song_done
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT_ROM,
    LOAD,
    WAIT_NOTE
  } state_e;

  localparam logic [IDX_BITS-1:0] IDX_LAST = '1;
  localparam logic [IDX_BITS-1:0] IDX_ONE  =
    {{(IDX_BITS-1){1'b0}}, 1'b1};

  state_e               state_q, state_d;
  logic [IDX_BITS-1:0]  idx_q, idx_d;
  logic [SONG_BITS-1:0] song_q, song_d;
  logic                 play_q;
  logic                 guard_q, guard_d;
  logic [5:0]           note_q, note_d;
  logic [5:0]           dur_q, dur_d;

  logic play_rise;
  logic song_chg;
  logic end_mark;
  logic last_slot;

  assign play_rise = play & ~play_q;
  assign song_chg  = (state_q != IDLE) && (song != song_q);
  assign end_mark  = (rom_data[5:0] == 6'd0);
  assign last_slot = (idx_q == IDX_LAST);

  // Both address fields are flops, so the ROM address is registered.
  assign rom_addr = {song_q, idx_q};
  assign note     = note_q;
  assign duration = dur_q;

  // Previous play level, for rising-edge detection in IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      play_q <= 1'b0;
    end else begin
      play_q <= play;
    end
  end

  // Sequencer state and captured note registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      song_q  <= '0;
      guard_q <= 1'b0;
      note_q  <= '0;
      dur_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      song_q  <= song_d;
      guard_q <= guard_d;
      note_q  <= note_d;
      dur_q   <= dur_d;
    end
  end

  // Next-state logic; a song change preempts every other move.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    song_d    = song_q;
    guard_d   = guard_q;
    note_d    = note_q;
    dur_d     = dur_q;
    new_note  = (state_q == LOAD);
    song_done = 1'b0;

    if (song_chg) begin
      song_d  = song;
      idx_d   = '0;
      guard_d = 1'b0;
      state_d = FETCH;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (play_rise) begin
            song_d  = song;
            idx_d   = '0;
            state_d = FETCH;
          end
        end
        FETCH: begin
          state_d = WAIT_ROM;
        end
        WAIT_ROM: begin
          if (end_mark) begin
            song_done = 1'b1;
            idx_d     = '0;
            state_d   = IDLE;
          end else begin
            note_d  = rom_data[11:6];
            dur_d   = rom_data[5:0];
            state_d = LOAD;
          end
        end
        LOAD: begin
          guard_d = 1'b1;
          state_d = WAIT_NOTE;
        end
        WAIT_NOTE: begin
          // The player needs one cycle to see the new note, so the
          // first WAIT_NOTE cycle ignores a stale note_done.
          if (guard_q) begin
            guard_d = 1'b0;
          end else if (note_done & play) begin
            if (last_slot) begin
              song_done = 1'b1;
              idx_d     = '0;
              state_d   = IDLE;
            end else begin
              idx_d   = idx_q + IDX_ONE;
              state_d = FETCH;
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_song_reader.sv
// tb_song_reader: random ROM contents, songs checked against a
// cycle-count model derived from the note/marker sequence.
module tb_song_reader;

  logic        clk;
  logic        reset;
  logic        play;
  logic [1:0]  song;
  logic        note_done;
  logic [6:0]  rom_addr;
  logic [11:0] rom_data;
  logic [5:0]  note;
  logic [5:0]  duration;
  logic        new_note;
  logic        song_done;

  logic [11:0] mem [128];

  int nvec;
  int nerr;

  song_reader dut (
    .clk       (clk),
    .reset     (reset),
    .play      (play),
    .song      (song),
    .note_done (note_done),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .note      (note),
    .duration  (duration),
    .new_note  (new_note),
    .song_done (song_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous ROM: one cycle of read latency.
  always @(posedge clk) rom_data <= mem[rom_addr];

  task automatic step();
    @(negedge clk);
  endtask

  // Songs 0 and 3 have no marker, song 2 ends at slot 3,
  // song 1 starts with 0x15/0x06 and ends at a random slot.
  task automatic init_mem();
    int r;
    for (int i = 0; i < 128; i++) begin
      mem[i] = {6'($urandom), 6'(1 + $urandom_range(62))};
    end
    mem[32] = {6'h15, 6'h06};
    r = $urandom_range(31, 1);
    mem[32 + r][5:0] = 6'd0;
    mem[67][5:0] = 6'd0;
  endtask

  // Number of notes played before the first zero duration.
  function automatic int song_len(input int s);
    for (int i = 0; i < 32; i++) begin
      if (mem[s * 32 + i][5:0] == 6'd0) return i;
    end
    return 32;
  endfunction

  task automatic do_reset();
    reset = 1'b0;
    play = 1'b0;
    note_done = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
  endtask

  // Plays song s with note_done held high and checks every cycle:
  // strobe k at cycle 3+5k, fetch k at cycle 1+5k, song_done at the
  // marker's WAIT_ROM cycle or at the 32nd note's completion.
  task automatic run_song(input int s, input string tag);
    int len;
    int done_c;
    int nfetch;
    int k;
    bit exp_nn;
    bit exp_sd;
    bit have;
    logic [5:0] en;
    logic [5:0] ed;
    logic [6:0] ea;
    len = song_len(s);
    done_c = (len == 32) ? 160 : 5 * len + 2;
    nfetch = (len == 32) ? 32 : len + 1;
    have = 1'b0;
    en = '0;
    ed = '0;
    note_done = 1'b1;
    play = 1'b0;
    step();
    song = s[1:0];
    play = 1'b1;
    for (int c = 1; c <= done_c + 10; c++) begin
      step();
      exp_nn = (c >= 3) && ((c - 3) % 5 == 0) && ((c - 3) / 5 < len);
      exp_sd = (c == done_c);
      if (exp_nn) begin
        k = (c - 3) / 5;
        en = mem[s * 32 + k][11:6];
        ed = mem[s * 32 + k][5:0];
        have = 1'b1;
      end
      nvec++;
      if (new_note !== exp_nn) begin
        nerr++;
        $display("FAIL %s new_note c=%0d got=%b exp=%b",
                 tag, c, new_note, exp_nn);
      end
      nvec++;
      if (song_done !== exp_sd) begin
        nerr++;
        $display("FAIL %s song_done c=%0d got=%b exp=%b",
                 tag, c, song_done, exp_sd);
      end
      if (have) begin
        nvec++;
        if (note !== en || duration !== ed) begin
          nerr++;
          $display("FAIL %s note c=%0d got=%h/%h exp=%h/%h",
                   tag, c, note, duration, en, ed);
        end
      end
      if ((c - 1) % 5 == 0 && (c - 1) / 5 < nfetch) begin
        ea = 7'(s * 32 + (c - 1) / 5);
        nvec++;
        if (rom_addr !== ea) begin
          nerr++;
          $display("FAIL %s rom_addr c=%0d got=%h exp=%h",
                   tag, c, rom_addr, ea);
        end
      end
    end
    ea = 7'(s * 32);
    nvec++;
    if (rom_addr !== ea) begin
      nerr++;
      $display("FAIL %s idx_rewind got=%h exp=%h", tag, rom_addr, ea);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    play = 1'b0;
    song = 2'd0;
    note_done = 1'b0;
    #2;
    nvec++;
    if ({rom_addr, note, duration, new_note, song_done} !== 21'd0) begin
      nerr++;
      $display("FAIL reset_outs got=%h exp=0",
               {rom_addr, note, duration, new_note, song_done});
    end
    step();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      nvec++;
      if (new_note !== 1'b0 || rom_addr !== 7'd0) begin
        nerr++;
        $display("FAIL reset_idle got=%b/%h exp=0/0", new_note, rom_addr);
      end
    end
  endtask

  task automatic test_first_note();
    run_song(1, "song1");
  endtask

  task automatic test_end_marker();
    run_song(2, "song2");
    run_song(2, "song2_again");
  endtask

  task automatic test_full_song();
    run_song(0, "full0");
  endtask

  task automatic test_random_songs();
    for (int i = 0; i < 3; i++) begin
      init_mem();
      run_song($urandom_range(3), "rand");
    end
  endtask

  task automatic test_pause();
    logic [5:0] n0;
    logic [5:0] d0;
    do_reset();
    note_done = 1'b1;
    song = 2'd3;
    play = 1'b1;
    step();
    step();
    step();
    n0 = mem[96][11:6];
    d0 = mem[96][5:0];
    nvec++;
    if (new_note !== 1'b1 || note !== n0 || duration !== d0) begin
      nerr++;
      $display("FAIL pause_first got=%b %h/%h exp=1 %h/%h",
               new_note, note, duration, n0, d0);
    end
    step();
    play = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step();
      nvec++;
      if (new_note !== 1'b0 || song_done !== 1'b0 ||
          note !== n0 || duration !== d0) begin
        nerr++;
        $display("FAIL pause_hold i=%0d got=%b%b %h/%h exp=00 %h/%h",
                 i, new_note, song_done, note, duration, n0, d0);
      end
    end
    play = 1'b1;
    step();
    nvec++;
    if (rom_addr !== 7'h61 || new_note !== 1'b0) begin
      nerr++;
      $display("FAIL resume_fetch got=%h/%b exp=61/0", rom_addr, new_note);
    end
    step();
    nvec++;
    if (new_note !== 1'b0) begin
      nerr++;
      $display("FAIL resume_early got=%b exp=0", new_note);
    end
    step();
    nvec++;
    if (new_note !== 1'b1 || note !== mem[97][11:6] ||
        duration !== mem[97][5:0]) begin
      nerr++;
      $display("FAIL resume_note got=%b %h/%h exp=1 %h",
               new_note, note, duration, mem[97]);
    end
  endtask

  task automatic test_song_change();
    do_reset();
    note_done = 1'b1;
    song = 2'd0;
    play = 1'b1;
    for (int c = 1; c <= 28; c++) step();
    nvec++;
    if (new_note !== 1'b1 || note !== mem[5][11:6]) begin
      nerr++;
      $display("FAIL chg_note5 got=%b %h exp=1 %h",
               new_note, note, mem[5][11:6]);
    end
    step();
    step();
    song = 2'd3;
    nvec++;
    if (song_done !== 1'b0) begin
      nerr++;
      $display("FAIL chg_done got=%b exp=0", song_done);
    end
    step();
    nvec++;
    if (rom_addr !== 7'h60 || song_done !== 1'b0) begin
      nerr++;
      $display("FAIL chg_addr got=%h/%b exp=60/0", rom_addr, song_done);
    end
    step();
    step();
    nvec++;
    if (new_note !== 1'b1 || note !== mem[96][11:6] ||
        duration !== mem[96][5:0]) begin
      nerr++;
      $display("FAIL chg_note got=%b %h/%h exp=1 %h",
               new_note, note, duration, mem[96]);
    end
  endtask

  task automatic test_reset_midsong();
    do_reset();
    note_done = 1'b0;
    song = 2'd3;
    play = 1'b1;
    step();
    step();
    step();
    nvec++;
    if (new_note !== 1'b1) begin
      nerr++;
      $display("FAIL rst_load got=%b exp=1", new_note);
    end
    #1 reset = 1'b0;
    #1;
    nvec++;
    if ({rom_addr, note, duration, new_note, song_done} !== 21'd0) begin
      nerr++;
      $display("FAIL rst_async got=%h exp=0",
               {rom_addr, note, duration, new_note, song_done});
    end
    step();
    step();
    nvec++;
    if ({rom_addr, note, duration, new_note, song_done} !== 21'd0) begin
      nerr++;
      $display("FAIL rst_hold got=%h exp=0",
               {rom_addr, note, duration, new_note, song_done});
    end
    reset = 1'b1;
    step();
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    rom_data = '0;
    init_mem();
    test_reset();
    test_first_note();
    test_end_marker();
    test_full_song();
    test_pause();
    test_song_change();
    test_reset_midsong();
    do_reset();
    test_random_songs();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
